stage2_decode: RTL

Second stage of the multi-cycle datapath, directly downstream of Stage1's shared instruction/data cache port. It captures the word read by Stage1 into the Instruction Register (IR) or Memory Data Register (MDR). It reads the register file into the A/B latches and produces the extended immediate. It also hosts the register-file write port used by write-back (ALU result or MDR).

---
 rtl/stage2_decode_pkg.sv | 39 +++
 rtl/stage2_decode_regfile.sv | 36 +++
 rtl/stage2_decode.sv | 102 ++++++++++
 3 files changed

// File: rtl/stage2_decode_pkg.sv
// Shared definitions for the decode stage and the control FSM that drives it.
//   - Control-vector bit positions for the bits consumed by stage 2.
//   - Instruction field positions (rs, rt, rd, imm).
//   - ctl_t / decode_ctl(): named view of the control bits used here.
package stage2_decode_pkg;

  localparam int CTL_W        = 22;
  localparam int CTL_IRWRITE  = 14;
  localparam int CTL_REGWRITE = 13;
  localparam int CTL_REGDST   = 12;
  localparam int CTL_MEMTOREG = 11;
  localparam int CTL_EXTOP    = 10;

  localparam int FIELD_W = 5;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 16;

  typedef struct packed {
    logic ir_write;
    logic reg_write;
    logic reg_dst;     // 1 = rd, 0 = rt
    logic mem_to_reg;  // 1 = MDR, 0 = ALU result
    logic ext_op;      // 1 = sign-extend, 0 = zero-extend
  } ctl_t;

  function automatic ctl_t decode_ctl(input logic [CTL_W-1:0] c);
    ctl_t r;
    r.ir_write   = c[CTL_IRWRITE];
    r.reg_write  = c[CTL_REGWRITE];
    r.reg_dst    = c[CTL_REGDST];
    r.mem_to_reg = c[CTL_MEMTOREG];
    r.ext_op     = c[CTL_EXTOP];
    return r;
  endfunction

endpackage

// File: rtl/stage2_decode_regfile.sv
// Register file: 2 asynchronous read ports, 1 synchronous write port.
// Register 0 reads as zero and ignores writes; synchronous clear on reset.
//   clk, reset          : clock, synchronous active-high reset
//   we_i/waddr_i/wdata_i: write port
//   raddr_a_i/rdata_a_o : read port A
//   raddr_b_i/rdata_b_o : read port B
module stage2_decode_regfile #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_a_i,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/stage2_decode.sv
// Decode stage of the multi-cycle datapath.
// Captures the Stage1 word into IR (on IRWrite) and MDR (every edge), reads
// the register file into the A/B latches using the current IR fields, extends
// the immediate, and hosts the write-back port.
//   clk, reset    : clock, synchronous active-high reset
//   control       : global control vector (bits 14..10 used)
//   instr_data_in : word from Stage1
//   alu_result    : ALU write-back candidate
//   ir_out/mdr_out: IR and MDR contents
//   reg_a/reg_b   : A/B latches (rs/rt operands)
//   imm_ext       : extended IR[15:0], combinational
module stage2_decode
  import stage2_decode_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CTL_W-1:0]  control,
  input  logic [DATA_W-1:0] instr_data_in,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] ir_out,
  output logic [DATA_W-1:0] mdr_out,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b,
  output logic [DATA_W-1:0] imm_ext
);

  localparam int AW = $clog2(NUM_REGS);

  ctl_t ctl;
  assign ctl = decode_ctl(control);

  logic [DATA_W-1:0] ir_q, ir_d, mdr_q, mdr_d, a_q, a_d, b_q, b_d;
  logic [AW-1:0]     rs, rt, rd, waddr;
  logic [DATA_W-1:0] wdata, rf_a, rf_b;
  logic              wr_en;
  logic [IMM_W-1:0]  imm;

  // Fields always come from the pre-edge IR, so an IR load and an A/B
  // capture on the same edge see the old instruction.
  assign rs    = ir_q[RS_LSB +: AW];
  assign rt    = ir_q[RT_LSB +: AW];
  assign rd    = ir_q[RD_LSB +: AW];
  assign imm   = ir_q[IMM_LSB +: IMM_W];

  assign waddr = ctl.reg_dst ? rd : rt;
  assign wdata = ctl.mem_to_reg ? mdr_q : alu_result;
  assign wr_en = ctl.reg_write && (waddr != '0);

  stage2_decode_regfile #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .AW      (AW)
  ) u_rf (
    .clk      (clk),
    .reset    (reset),
    .we_i     (wr_en),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .raddr_a_i(rs),
    .raddr_b_i(rt),
    .rdata_a_o(rf_a),
    .rdata_b_o(rf_b)
  );

  always_comb begin
    ir_d  = ctl.ir_write ? instr_data_in : ir_q;
    mdr_d = instr_data_in;
    // Write-through: a same-edge write to rs/rt lands in A/B directly.
    a_d   = (wr_en && (waddr == rs)) ? wdata : rf_a;
    b_d   = (wr_en && (waddr == rt)) ? wdata : rf_b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q  <= '0;
      mdr_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      ir_q  <= ir_d;
      mdr_q <= mdr_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

  assign ir_out  = ir_q;
  assign mdr_out = mdr_q;
  assign reg_a   = a_q;
  assign reg_b   = b_q;
  assign imm_ext = ctl.ext_op ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm}
                              : {{(DATA_W-IMM_W){1'b0}}, imm};

  // Opcode bits and control bits owned by other stages.
  logic unused_bits;
  assign unused_bits = ^{ir_q[DATA_W-1:RS_LSB+AW], control[CTL_W-1:CTL_IRWRITE+1],
                         control[CTL_EXTOP-1:0]};

endmodule
